// File: rtl/mips_multicycle_ctrl_if.sv
// Control-to-datapath bundle for the multicycle MIPS sequencer.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zout;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zout, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, illegal_op
    );

    modport slave (
        output opcode, funct, zout, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore multicycle control FSM for the custom MIPS core with memory ready/request pacing.
// Optional MIPS_CTRL_ILLEGAL_TRAP_EN: undefined opcode/funct locks into TRAP with sticky illegal_op.
module mips_multicycle_ctrl (
    input  logic                        clk,
    input  logic                        rst_n,
    mips_multicycle_ctrl_if.master      bus
);
    typedef enum logic [3:0] {
        ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_EXEC_I, ST_WB_I,
        ST_MEM_ADDR, ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_BRANCH, ST_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLT   = 6'b000110;
    localparam logic [5:0] OP_SUBI  = 6'b001000;

    localparam logic [2:0] ALU_NAND = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_MOVE = 3'b101;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = ST_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = ST_FETCH;
`endif

    state_t     state_q, state_d;
    logic [2:0] r_alu;
    logic       r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    // R-type funct decode; reused in WB_R so alu_control stays stable through write-back.
    always_comb begin
        r_alu   = ALU_NAND;
        r_valid = 1'b1;
        case (bus.funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_NAND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            6'b000000: r_alu = ALU_SLL;
            6'b000110: r_alu = ALU_MOVE;
            default:   r_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'b00;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = ALU_NAND;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                bus.mem_req     = 1'b1;
                bus.alu_src_b   = 2'b01;
                bus.alu_control = ALU_ADD;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                bus.alu_src_b   = 2'b11;
                bus.alu_control = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:       state_d = ST_EXEC_R;
                    OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BLT: state_d = ST_BRANCH;
                    OP_SUBI:        state_d = ST_EXEC_I;
                    default:        state_d = ILLEGAL_NEXT;
                endcase
            end
            ST_EXEC_R: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = r_alu;
                state_d         = r_valid ? ST_WB_R : ILLEGAL_NEXT;
            end
            ST_WB_R: begin
                bus.reg_write   = 1'b1;
                bus.reg_dst     = 1'b1;
                bus.alu_control = r_alu;
                state_d         = ST_FETCH;
            end
            ST_EXEC_I: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = ALU_SUB;
                state_d         = ST_WB_I;
            end
            ST_WB_I: begin
                bus.reg_write = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = ALU_ADD;
                state_d         = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = ST_WB_MEM;
            end
            ST_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = 2'b01;
                if (bus.opcode == OP_BEQ) begin
                    bus.alu_control = ALU_SUB;
                    bus.pc_write    = bus.zout;
                end else begin
                    bus.alu_control = ALU_SLT;
                    bus.pc_write    = ~bus.zout;
                end
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RESET;
        endcase
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | (state_d == ST_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; follows MIPS_CTRL_ILLEGAL_TRAP_EN
// so the illegal-instruction expectations match the build under test.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
    //  alu_src_a, alu_src_b, alu_control, illegal_op}
    logic [16:0] obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                  bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_control, bus.illegal_op};

    function automatic logic [16:0] pk(input logic mreq, input logic mwe, input logic io,
                                       input logic irw, input logic pcw, input logic [1:0] psrc,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic ill);
        return {mreq, mwe, io, irw, pcw, psrc, rw, rd, m2r, sa, sb, alu, ill};
    endfunction

    logic [16:0] v_zero, v_fw, v_fr, v_dec, v_maddr, v_mwr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.opcode = 6'b0; bus.funct = 6'b0; bus.zout = 1'b0; bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        #1;
        if (obs !== v_zero) begin
            $display("FAIL reset_hold: got %b required %b", obs, v_zero); miscompares++;
        end
        vectors++;
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        if (obs !== v_zero) begin
            $display("FAIL reset_cycle: got %b required %b", obs, v_zero); miscompares++;
        end
        vectors++;
        tick();
        if (obs !== v_fw) begin
            $display("FAIL reset_to_fetch: got %b required %b", obs, v_fw); miscompares++;
        end
        vectors++;
        tick();
    endtask

    task automatic test_rtype();
        logic [5:0]  fn  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b000000, 6'b000110};
        logic [2:0]  alu [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101};
        logic [16:0] ex  [5];
        logic        rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            ex[0] = v_fr;
            ex[1] = v_dec;
            ex[2] = pk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,alu[k],0);
            ex[3] = pk(0,0,0,0,0,2'b00,1,1,0,0,2'b00,alu[k],0);
            ex[4] = v_fw;
            bus.opcode = 6'b000000; bus.funct = fn[k];
            for (int i = 0; i < 5; i++) begin
                bus.mem_ready = rdy[i];
                #1;
                if (obs !== ex[i]) begin
                    $display("FAIL rtype funct=%b step %0d: got %b required %b",
                             fn[k], i, obs, ex[i]);
                    miscompares++;
                end
                vectors++;
                tick();
            end
        end
    endtask

    task automatic test_lw_waits();
        logic [16:0] ex  [10];
        logic        rdy [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        int          irw_cnt = 0;
        ex = '{v_fw, v_fw, v_fr, v_dec, v_maddr,
               pk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0),
               pk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0),
               pk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0),
               pk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,3'b000,0),
               v_fw};
        bus.opcode = 6'b100011; bus.funct = 6'b010101;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            if (i < 9 && bus.ir_write) irw_cnt++;
            if (obs !== ex[i]) begin
                $display("FAIL lw_wait step %0d: got %b required %b", i, obs, ex[i]);
                miscompares++;
            end
            vectors++;
            tick();
        end
        if (irw_cnt !== 1) begin
            $display("FAIL lw_ir_write_pulses: got %0d required 1", irw_cnt); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_sw_subi();
        logic [16:0] ex  [5];
        logic        rdy [5] = '{1, 0, 0, 1, 0};
        ex = '{v_fr, v_dec, v_maddr, v_mwr, v_fw};
        bus.opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            if (obs !== ex[i]) begin
                $display("FAIL sw step %0d: got %b required %b", i, obs, ex[i]); miscompares++;
            end
            vectors++;
            tick();
        end
        ex = '{v_fr, v_dec, pk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b110,0),
               pk(0,0,0,0,0,2'b00,1,0,0,0,2'b00,3'b000,0), v_fw};
        rdy = '{1, 0, 0, 0, 0};
        bus.opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            if (obs !== ex[i]) begin
                $display("FAIL subi step %0d: got %b required %b", i, obs, ex[i]); miscompares++;
            end
            vectors++;
            tick();
        end
    endtask

    task automatic test_branch();
        logic [5:0]  op  [4] = '{6'b000110, 6'b000110, 6'b000100, 6'b000100};
        logic        z   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        pcw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  alu [4] = '{3'b111, 3'b111, 3'b110, 3'b110};
        logic [16:0] ex  [4];
        logic        rdy [4] = '{1, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            ex = '{v_fr, v_dec, pk(0,0,0,0,pcw[k],2'b01,0,0,0,1,2'b00,alu[k],0), v_fw};
            bus.opcode = op[k]; bus.zout = z[k];
            for (int i = 0; i < 4; i++) begin
                bus.mem_ready = rdy[i];
                #1;
                if (obs !== ex[i]) begin
                    $display("FAIL branch op=%b zout=%b step %0d: got %b required %b",
                             op[k], z[k], i, obs, ex[i]);
                    miscompares++;
                end
                vectors++;
                tick();
            end
        end
        bus.zout = 1'b0;
    endtask

    task automatic test_reset_midtxn();
        bus.opcode = 6'b101011;
        bus.mem_ready = 1'b1; tick();
        bus.mem_ready = 1'b0; tick(); tick();
        #1;
        if (obs !== v_mwr) begin
            $display("FAIL midrst_in_memwr: got %b required %b", obs, v_mwr); miscompares++;
        end
        vectors++;
        rst_n = 1'b0;
        #1;
        if ({bus.mem_req, bus.mem_we} !== 2'b00 || obs !== v_zero) begin
            $display("FAIL midrst_drop: got %b required %b", obs, v_zero); miscompares++;
        end
        vectors++;
        tick();
        rst_n = 1'b1;
        #1;
        if (obs !== v_zero) begin
            $display("FAIL midrst_reset_cycle: got %b required %b", obs, v_zero); miscompares++;
        end
        vectors++;
        tick();
        if (obs !== v_fw) begin
            $display("FAIL midrst_fetch: got %b required %b", obs, v_fw); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_illegal();
        logic [5:0]  op [2] = '{6'b000000, 6'b111111};
        logic [16:0] v_after;
        int          rw_seen;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        v_after = pk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,3'b000,1);
`else
        v_after = v_fw;
`endif
        for (int k = 0; k < 2; k++) begin
            rw_seen = 0;
            bus.opcode = op[k]; bus.funct = 6'b111111;
            bus.mem_ready = 1'b1; #1;
            if (obs !== v_fr) begin
                $display("FAIL illegal%0d fetch: got %b required %b", k, obs, v_fr); miscompares++;
            end
            vectors++;
            tick();
            bus.mem_ready = 1'b0; #1;
            if (obs !== v_dec) begin
                $display("FAIL illegal%0d decode: got %b required %b", k, obs, v_dec); miscompares++;
            end
            vectors++;
            tick();
            if (k == 0) begin
                #1;
                if (bus.reg_write) rw_seen++;
                if ({bus.alu_src_a, bus.alu_src_b, bus.mem_req} !== 4'b1000) begin
                    $display("FAIL illegal_funct exec: got %b required 1000",
                             {bus.alu_src_a, bus.alu_src_b, bus.mem_req});
                    miscompares++;
                end
                vectors++;
                tick();
            end
            for (int i = 0; i < 3; i++) begin
                bus.mem_ready = 1'b1;
                #1;
                if (bus.reg_write) rw_seen++;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                if (obs !== v_after) begin
                    $display("FAIL illegal%0d trap cycle %0d: got %b required %b",
                             k, i, obs, v_after);
                    miscompares++;
                end
                vectors++;
                tick();
`else
                if (i == 0) begin
                    bus.mem_ready = 1'b0;
                    #1;
                    if (obs !== v_after) begin
                        $display("FAIL illegal%0d nop_fetch: got %b required %b",
                                 k, obs, v_after);
                        miscompares++;
                    end
                    vectors++;
                end
`endif
            end
            if (rw_seen !== 0) begin
                $display("FAIL illegal%0d reg_write: got %0d required 0", k, rw_seen);
                miscompares++;
            end
            vectors++;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            rst_n = 1'b0;
            #1;
            if (obs !== v_zero) begin
                $display("FAIL illegal%0d reset_clear: got %b required %b", k, obs, v_zero);
                miscompares++;
            end
            vectors++;
            tick();
            rst_n = 1'b1;
            bus.mem_ready = 1'b0;
            tick();
`endif
            bus.mem_ready = 1'b0;
            #1;
            if (obs !== v_fw) begin
                $display("FAIL illegal%0d resume_fetch: got %b required %b", k, obs, v_fw);
                miscompares++;
            end
            vectors++;
        end
    endtask

    initial begin
        v_zero  = '0;
        v_fw    = pk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,3'b010,0);
        v_fr    = pk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,3'b010,0);
        v_dec   = pk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b010,0);
        v_maddr = pk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010,0);
        v_mwr   = pk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0);
        test_reset();
        test_rtype();
        test_lw_waits();
        test_sw_subi();
        test_branch();
        test_reset_midtxn();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control sequencer for the custom MIPS core. It drives the ALU's `alu_control` code, the datapath mux selects and the register, PC and memory write enables, and it consumes the ALU's `zout` flag to resolve branches. It sits between the instruction register (which supplies opcode/funct) and the shared datapath, and paces every instruction through a Moore FSM with a ready/request handshake to unified memory.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0].
- `zout` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write qualifier for `mem_req`.
- `iord` out 1: address source, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the IR.
- `pc_write` out 1: unconditional PC load.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut (branch target).
- `reg_write` out 1: register file write.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_control` out 3: NAND 000, OR 001, ADD 010, SUB 110, SLT 111, SLL 100, MOVE 101.
- `illegal_op` out 1: sticky undefined-opcode flag.

## Operation
- Decided encodings:
  - R-type: opcode 000000, with funct add 100000, sub 100010, nand 100100, or 100101, slt 101010, sll 000000, move 000110.
  - Other opcodes: lw 100011, sw 101011, beq 000100, blt 000110, subi 001000.
- States:
  - RESET: all outputs 0. Goes to FETCH.
  - FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD. Held until `mem_ready`. In the `mem_ready` cycle, `ir_write`=1 and `pc_write`=1 with `pc_src`=00, then the FSM goes to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, ADD. This forms the branch target into ALUOut.
    - R-type goes to EXEC_R.
    - lw and sw go to MEM_ADDR.
    - beq and blt go to BRANCH.
    - subi goes to EXEC_I.
    - Any other opcode is handled per Configuration.
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_control` taken from funct. An undefined funct is handled like an undefined opcode. Goes to WB_R.
  - WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. `alu_control` is held. Goes to FETCH.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=10, SUB. Goes to WB_I.
  - WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, ADD. lw goes to MEM_RD; sw goes to MEM_WR.
  - MEM_RD: `mem_req`=1, `iord`=1. Waits for `mem_ready`, then goes to WB_MEM.
  - WB_MEM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Goes to FETCH.
  - MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. Waits for `mem_ready`, then goes to FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `pc_src`=01.
    - beq uses SUB and sets `pc_write` = `zout`.
    - blt uses SLT and sets `pc_write` = ~`zout`.
    - Goes to FETCH.
- `pc_write` in BRANCH and the `mem_ready`-qualified enables in FETCH are the only combinational (Mealy) dependencies on inputs. Every other output is a pure decode of the state.
- `mem_req` stays high until `mem_ready`. Once asserted it is never withdrawn before completion.

## Timing
- Cycle counts include the FETCH cycle and assume zero wait states:
  - R-type, subi, sw: 4.
  - lw: 5.
  - beq, blt: 3.
- Each memory wait state adds one cycle in FETCH, MEM_RD or MEM_WR.
- Asserting `rst_n` low forces RESET immediately, at any point including mid-transaction. All outputs go to 0 and `illegal_op` clears.
- After `rst_n` rises, the FSM spends one cycle in RESET, then enters FETCH.
- `mem_ready` outside a requesting state is ignored.

## Configuration
- `MIPS_CTRL_ILLEGAL_TRAP_EN` defined:
  - An undefined opcode in DECODE, or an undefined funct in EXEC_R, sends the FSM to TRAP. EXEC_R exits to TRAP before WB_R.
  - TRAP asserts all enables 0 and holds until reset.
  - `illegal_op` is set and stays sticky.
- `MIPS_CTRL_ILLEGAL_TRAP_EN` undefined:
  - An undefined opcode goes DECODE → FETCH, i.e. it executes as a NOP.
  - An undefined funct goes EXEC_R → FETCH with no `reg_write`.
  - `illegal_op` is tied to 0.

## Test plan
- Reset: `rst_n`=0 → all outputs 0. After release: 1 cycle in RESET, then FETCH with `mem_req`=1, `iord`=0, `alu_control`=010.
- add (000000/100000), `mem_ready`=1 in FETCH → 4 cycles. `alu_control`=010 in EXEC_R. `reg_write`=1, `reg_dst`=1 exactly in cycle 4.
- lw with 2 wait states in both FETCH and MEM_RD → 9 cycles total. `ir_write` pulses once. `mem_to_reg`=1 with `reg_write`=1 in the final cycle.
- blt with `zout`=0 → `pc_write`=1, `pc_src`=01, SLT (111). blt with `zout`=1 → `pc_write`=0. beq with `zout`=1 → `pc_write`=1, SUB (110).
- `rst_n` low while in MEM_WR with `mem_req`=1 → `mem_req`/`mem_we` drop the same cycle. Next instruction starts at FETCH.
- opcode 111111 → with the macro: TRAP, `illegal_op`=1 held, no `mem_req`. Without the macro: FETCH next, `reg_write` never asserted.
